// File: rtl/mod_updown_counter_if.sv
// Control and status bundle for one mod_updown_counter channel.
//   master : the controlling logic; drives enable/direction/clear/load, reads count and flags.
//   slave  : the counter itself.
// Signals:
//   i_en, i_dir, i_clear, i_load, i_load_value : step / load controls
//   o_counter                                  : registered count
//   o_tc                                       : next enabled step crosses a range end
//   o_wrap                                     : one-cycle wrap/saturate pulse
//   o_ovf_sticky                               : latched wrap indication
interface mod_updown_counter_if #(
    parameter int unsigned WIDTH = 3
);
    logic             i_en;
    logic             i_dir;
    logic             i_clear;
    logic             i_load;
    logic [WIDTH-1:0] i_load_value;
    logic [WIDTH-1:0] o_counter;
    logic             o_tc;
    logic             o_wrap;
    logic             o_ovf_sticky;

    modport master (
        output i_en, i_dir, i_clear, i_load, i_load_value,
        input  o_counter, o_tc, o_wrap, o_ovf_sticky
    );

    modport slave (
        input  i_en, i_dir, i_clear, i_load, i_load_value,
        output o_counter, o_tc, o_wrap, o_ovf_sticky
    );
endinterface

// File: rtl/mod_updown_counter.sv
// Up/down modulo counter clocked by a debounced push-button clock.
// Counts 0..MODULUS-1 with wrap or saturate behaviour, synchronous clear and clamped parallel
// load, plus terminal-count, wrap-pulse and sticky-overflow flags.
// Ports:
//   i_btn_clk : counting clock, rising edge
//   i_reset   : asynchronous, active-high reset to RESET_VALUE
//   bus       : slave side of mod_updown_counter_if (controls in, count and flags out)
module mod_updown_counter #(
    parameter int unsigned WIDTH       = 3,
    parameter int unsigned MODULUS     = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned SATURATE    = 0
) (
    input  logic                   i_btn_clk,
    input  logic                   i_reset,
    mod_updown_counter_if.slave    bus
);

    // Extra headroom bit so compares and increments never rely on 2^WIDTH rollover.
    localparam logic [WIDTH:0]   MaxVal   = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH:0]   OneExt   = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ResetCnt = WIDTH'(RESET_VALUE);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             sticky_q, sticky_d;

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   cnt_inc;
    logic [WIDTH:0]   cnt_dec;
    logic             at_max;
    logic             at_zero;

    always_comb begin
        cnt_ext  = {1'b0, cnt_q};
        load_ext = {1'b0, bus.i_load_value};
        cnt_inc  = cnt_ext + OneExt;
        cnt_dec  = cnt_ext - OneExt;
        at_max   = (cnt_ext == MaxVal);
        at_zero  = (cnt_ext == '0);
    end

    always_comb begin
        cnt_d    = cnt_q;
        wrap_d   = 1'b0;
        sticky_d = sticky_q;

        if (bus.i_clear) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end else if (bus.i_load) begin
            // Clamp so an out-of-range load can never leave the counter outside 0..MODULUS-1.
            cnt_d = (load_ext > MaxVal) ? MaxVal[WIDTH-1:0] : bus.i_load_value;
        end else if (bus.i_en) begin
            if (bus.i_dir) begin
                if (at_max) begin
                    wrap_d = 1'b1;
                    cnt_d  = (SATURATE != 0) ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_inc[WIDTH-1:0];
                end
            end else begin
                if (at_zero) begin
                    wrap_d = 1'b1;
                    cnt_d  = (SATURATE != 0) ? cnt_q : MaxVal[WIDTH-1:0];
                end else begin
                    cnt_d = cnt_dec[WIDTH-1:0];
                end
            end
            if (wrap_d) begin
                sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_btn_clk or posedge i_reset) begin
        if (i_reset) begin
            cnt_q    <= ResetCnt;
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end

    assign bus.o_counter    = cnt_q;
    assign bus.o_wrap       = wrap_q;
    assign bus.o_ovf_sticky = sticky_q;
    assign bus.o_tc         = bus.i_en & ~bus.i_clear & ~bus.i_load &
                              ((bus.i_dir & at_max) | (~bus.i_dir & at_zero));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Bench for mod_updown_counter: two instances with MODULUS=6, one wrapping (reset value 0) and
// one saturating (reset value 2), driven with the same directed vectors. An arithmetic model of
// each is compared on every falling edge; literal expectations pin the key scenarios.
module tb_mod_updown_counter;

    localparam int M = 6;

    logic       clk;
    logic       rst;
    logic       en, dir, clear, load;
    logic [2:0] lv;
    int         n_tests;
    int         n_fail;
    bit         check_en;

    mod_updown_counter_if #(.WIDTH(3)) if0 ();
    mod_updown_counter_if #(.WIDTH(3)) if1 ();

    assign if0.i_en = en;    assign if0.i_dir = dir;   assign if0.i_clear = clear;
    assign if0.i_load = load; assign if0.i_load_value = lv;
    assign if1.i_en = en;    assign if1.i_dir = dir;   assign if1.i_clear = clear;
    assign if1.i_load = load; assign if1.i_load_value = lv;

    mod_updown_counter #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(0), .SATURATE(0)) dut_wrap (
        .i_btn_clk (clk),
        .i_reset   (rst),
        .bus       (if0)
    );

    mod_updown_counter #(.WIDTH(3), .MODULUS(6), .RESET_VALUE(2), .SATURATE(1)) dut_sat (
        .i_btn_clk (clk),
        .i_reset   (rst),
        .bus       (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: take a signed step, then decide by range crossing whether to wrap or hold.
    function automatic void model_step(input int m, input bit sat, input int cnt, input bit sticky,
                                       input bit c, input bit l, input int lval, input bit e,
                                       input bit d, output int nc, output bit nw, output bit ns);
        int raw;
        nc = cnt;
        nw = 1'b0;
        ns = sticky;
        if (c) begin
            nc = 0;
            ns = 1'b0;
        end else if (l) begin
            nc = (lval < m) ? lval : m - 1;
        end else if (e) begin
            raw = cnt + (d ? 1 : -1);
            if (raw < 0 || raw >= m) begin
                nw = 1'b1;
                ns = 1'b1;
                nc = sat ? cnt : (raw + m) % m;
            end else begin
                nc = raw;
            end
        end
    endfunction

    function automatic bit model_tc(input int m, input int cnt);
        return en && !clear && !load && ((dir && cnt == m - 1) || (!dir && cnt == 0));
    endfunction

    int m0_cnt, m1_cnt;
    bit m0_wrap, m1_wrap, m0_sticky, m1_sticky;

    always @(posedge clk or posedge rst) begin : model0
        int nc;
        bit nw, ns;
        if (rst) begin
            m0_cnt <= 0; m0_wrap <= 1'b0; m0_sticky <= 1'b0;
        end else begin
            model_step(M, 1'b0, m0_cnt, m0_sticky, clear, load, int'(lv), en, dir, nc, nw, ns);
            m0_cnt <= nc; m0_wrap <= nw; m0_sticky <= ns;
        end
    end

    always @(posedge clk or posedge rst) begin : model1
        int nc;
        bit nw, ns;
        if (rst) begin
            m1_cnt <= 2; m1_wrap <= 1'b0; m1_sticky <= 1'b0;
        end else begin
            model_step(M, 1'b1, m1_cnt, m1_sticky, clear, load, int'(lv), en, dir, nc, nw, ns);
            m1_cnt <= nc; m1_wrap <= nw; m1_sticky <= ns;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en && !rst) begin
            chk("w.counter", int'(if0.o_counter), m0_cnt);
            chk("w.wrap", int'(if0.o_wrap), int'(m0_wrap));
            chk("w.sticky", int'(if0.o_ovf_sticky), int'(m0_sticky));
            chk("w.tc", int'(if0.o_tc), int'(model_tc(M, m0_cnt)));
            chk("s.counter", int'(if1.o_counter), m1_cnt);
            chk("s.wrap", int'(if1.o_wrap), int'(m1_wrap));
            chk("s.sticky", int'(if1.o_ovf_sticky), int'(m1_sticky));
            chk("s.tc", int'(if1.o_tc), int'(model_tc(M, m1_cnt)));
        end
    end

    // Apply inputs, let one rising edge sample them, return shortly after that edge.
    task automatic cyc(input bit e, input bit d, input bit c, input bit l, input logic [2:0] v);
        en = e; dir = d; clear = c; load = l; lv = v;
        @(posedge clk);
        #2;
    endtask

    initial begin
        int up_exp [7];
        up_exp = '{1, 2, 3, 4, 5, 0, 1};
        n_tests = 0;
        n_fail = 0;
        check_en = 1'b0;
        en = 1'b0; dir = 1'b0; clear = 1'b0; load = 1'b0; lv = '0;
        rst = 1'b1;

        // Reset takes effect before any clock edge.
        #3;
        chk("rst.counter", int'(if0.o_counter), 0);
        chk("rst.wrap", int'(if0.o_wrap), 0);
        chk("rst.sticky", int'(if0.o_ovf_sticky), 0);
        chk("rst.s_counter", int'(if1.o_counter), 2);
        #4 rst = 1'b0;
        @(posedge clk);
        #2;
        check_en = 1'b1;

        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
            chk("up.counter", int'(if0.o_counter), up_exp[i]);
            chk("up.wrap", int'(if0.o_wrap), (i == 5) ? 1 : 0);
        end
        chk("up.sticky", int'(if0.o_ovf_sticky), 1);
        chk("up.s_hold", int'(if1.o_counter), 5);

        cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
        chk("clr.counter", int'(if0.o_counter), 0);
        chk("clr.sticky", int'(if0.o_ovf_sticky), 0);

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("dn.counter", int'(if0.o_counter), 5);
        chk("dn.wrap", int'(if0.o_wrap), 1);
        chk("dn.s_counter", int'(if1.o_counter), 0);
        chk("dn.s_wrap", int'(if1.o_wrap), 1);

        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("satup.s_counter", int'(if1.o_counter), 5);
        chk("satup.s_wrap", int'(if1.o_wrap), 1);
        chk("satup.counter", int'(if0.o_counter), 0);

        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd7);
        chk("ld7.counter", int'(if0.o_counter), 5);
        chk("ld7.wrap", int'(if0.o_wrap), 0);

        en = 1'b1; dir = 1'b1; clear = 1'b0; load = 1'b0;
        #1 chk("tc.up", int'(if0.o_tc), 1);
        dir = 1'b0;
        #1 chk("tc.down", int'(if0.o_tc), 0);
        en = 1'b0; dir = 1'b1;
        #1 chk("tc.dis", int'(if0.o_tc), 0);

        cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd3);
        chk("ldclr.counter", int'(if0.o_counter), 0);
        chk("ldclr.sticky", int'(if0.o_ovf_sticky), 0);

        cyc(1'b1, 1'b1, 1'b0, 1'b1, 3'd2);
        chk("lden.counter", int'(if0.o_counter), 2);
        chk("lden.wrap", int'(if0.o_wrap), 0);

        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("mid.counter", int'(if0.o_counter), 3);
        #1 rst = 1'b1;
        #1 chk("mid.rst", int'(if0.o_counter), 0);
        chk("mid.s_rst", int'(if1.o_counter), 2);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        chk("mid.next", int'(if0.o_counter), 1);
        chk("mid.s_next", int'(if1.o_counter), 3);

        // Idle, direction flips and more wraps for the model compare.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("idle.counter", int'(if0.o_counter), 1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        chk("flip.counter", int'(if0.o_counter), 5);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 3'd6);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0);

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
